md_unit_ctrl: RTL

- Sequencing controller for a shared multiply/divide resource in the E stage of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo commands from E-stage decode and models the fixed multi-cycle latency of each operation.
- Owns the architectural HI/LO registers.
- Raises a stall request to the hazard logic while a D-stage instruction that touches the MDU must wait.

---
 rtl/md_unit_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO: results commit MULT_CYCLES/DIV_CYCLES edges after start.
// No backpressure on commands; stall_md holds dependent D-stage MDU ops while a start or an operation is pending.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        req_md_d,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        stall_md
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]  state;
  logic [3:0]  counter;
  logic [31:0] tmp_hi;
  logic [31:0] tmp_lo;
  logic        tmp_wr;

  logic        is_mul;
  logic        is_div;
  logic        start_now;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;

  always_comb begin
    is_mul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div    = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    start_now = (state == ST_IDLE) && (is_mul || is_div);
  end

  assign busy     = (state == ST_BUSY);
  assign stall_md = req_md_d & (start_now | busy);

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    neg_a  = (md_op == OP_DIV) && src_a[31];
    neg_b  = (md_op == OP_DIV) && src_b[31];
    mag_a  = neg_a ? -src_a : src_a;
    mag_b  = neg_b ? -src_b : src_b;
    div_b  = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_u    = mag_a / div_b;
    r_u    = mag_a % div_b;
    quot   = (neg_a ^ neg_b) ? -q_u : q_u;
    rem    = neg_a ? -r_u : r_u;
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (md_op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi = rem;
        res_lo = quot;
        res_wr = (src_b != 32'd0);
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      counter <= 4'd0;
      tmp_hi  <= 32'd0;
      tmp_lo  <= 32'd0;
      tmp_wr  <= 1'b0;
      hi_out  <= 32'd0;
      lo_out  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_now) begin
            tmp_hi  <= res_hi;
            tmp_lo  <= res_lo;
            tmp_wr  <= res_wr;
            counter <= is_mul ? MULT_LOAD : DIV_LOAD;
            state   <= ST_BUSY;
          end else if (md_op == OP_MTHI) begin
            hi_out <= src_a;
          end else if (md_op == OP_MTLO) begin
            lo_out <= src_a;
          end
        end
        default: begin
          // Commands arriving while busy are dropped; the hazard unit keeps them from being legal.
          if (counter == 4'd1) begin
            if (tmp_wr) begin
              hi_out <= tmp_hi;
              lo_out <= tmp_lo;
            end
            counter <= 4'd0;
            state   <= ST_IDLE;
          end else begin
            counter <= counter - 4'd1;
          end
        end
      endcase
    end
  end

endmodule
